branch_pc_unit: RTL
===================

// Module: branch_pc_unit
// PURPOSE
//   Consumes N/Z/P from the condition-code register; owns the PC and BEN registers.
//   Latches branch-enable BEN from IR[11:9] and the current flags.
//   Computes effective addresses: ADDR1MUX + ADDR2MUX, optionally left-shifted by one.
//   The address-adder output feeds both the PC mux and the MARMUX gate. Controlled by the microsequencer.
// PARAMETERS
//   RESET_PC   16'h0000   PC value loaded on reset
// PORTS
//   clk        in   1    system clock, all state updates on posedge
//   rst        in   1    synchronous reset, active-high
//   IR         in   16   current instruction register
//   N, Z, P    in   1    registered condition codes
//   LD_BEN     in   1    load BEN this cycle
//   LD_PC      in   1    load PC this cycle
//   PCMUX      in   2    00 PC+2, 01 BUS, 10 ADDER, 11 reserved
//   ADDR1MUX   in   1    0 PC, 1 SR1
//   ADDR2MUX   in   2    00 zero, 01 sext(IR[5:0]), 10 sext(IR[8:0]), 11 sext(IR[10:0])
//   LSHF1      in   1    shift ADDR2MUX result left by 1 before the add
//   SR1        in   16   base register value from the register file
//   BUS        in   16   system bus
//   PC         out  16   program counter
//   BEN        out  1    branch enable
//   ADDR       out  16   address-adder result, combinational
//   stat_clr   in   1    clear branch statistics
//   br_count   out  16   BEN evaluations
//   taken_count out 16   evaluations with BEN=1
// BEHAVIOUR
//   - Reset (rst=1 at posedge):
//     - PC=RESET_PC with bit0 forced 0, BEN=0, both counters=0.
//     - rst overrides LD_PC, LD_BEN and stat_clr in the same cycle.
//   - BEN update: on LD_BEN, BEN <= (IR[11]&N)|(IR[10]&Z)|(IR[9]&P).
//     - N/Z/P are sampled at that edge, so a same-cycle CC load upstream yields the old flags.
//     - Without LD_BEN, BEN holds.
//   - ADDR is combinational:
//     - ADDR = (ADDR1MUX?SR1:PC) + (LSHF1 ? op2<<1 : op2).
//     - Arithmetic is mod 2^16; the carry is dropped and the shifted-out MSB is discarded.
//   - PC update on LD_PC selects the new value by PCMUX:
//     - PCMUX=00: PC+2 mod 2^16 (xFFFE -> x0000).
//     - PCMUX=01: BUS.
//     - PCMUX=10: ADDR.
//     - PCMUX=11: PC holds.
//     - Bit0 of every loaded value is forced to 0 (word alignment).
//   - Without LD_PC, PC holds. Outputs become valid 1 cycle after the loading edge.
//   - LD_BEN and LD_PC may assert together.
//     - Both updates occur independently.
//     - ADDR uses the pre-update PC.
// CONFIGURATION
//   BRANCH_STATS_EN
//   - Defined: two 16-bit counters.
//     - br_count increments on each LD_BEN.
//     - taken_count increments when the newly computed BEN=1.
//     - Both saturate at 16'hFFFF.
//     - stat_clr zeroes both and takes priority over an increment in the same cycle.
//   - Undefined: counters are not built; br_count and taken_count are tied to 0 and stat_clr is ignored.
//   - Ports are present in both builds.
// TESTING
//   - Reset: any prior state, rst=1 one cycle -> PC=RESET_PC, BEN=0, counters=0.
//   - BEN taken: IR=x0E00 (nzp=111), N=0 Z=1 P=0, LD_BEN -> BEN=1.
//     BEN not taken: IR=x0800 (n only), same flags -> BEN=0.
//   - Branch target: PC=x3000, IR[8:0]=x1FF, ADDR2MUX=10, LSHF1=1, ADDR1MUX=0, PCMUX=10, LD_PC -> PC=x2FFE.
//   - Wrap and hold:
//     - PC=xFFFE, PCMUX=00, LD_PC -> PC=x0000.
//     - BUS=x1235, PCMUX=01 -> PC=x1234.
//     - PCMUX=11 -> PC unchanged.
//   - Base+offset: SR1=x4000, ADDR1MUX=1, ADDR2MUX=01, IR[5:0]=x20, LSHF1=0 -> ADDR=x3FE0.
//   - Stats (BRANCH_STATS_EN):
//     - 3 LD_BEN, 2 taken -> br_count=3, taken_count=2.
//     - Preload xFFFF + LD_BEN -> count stays xFFFF.
//     - stat_clr with LD_BEN in the same cycle -> counters=0.

Source files
------------

// File: rtl/branch_pc_unit.sv
// branch_pc_unit
//   Owns the program counter and the branch-enable flag. BEN is computed
//   from IR[11:9] and the registered N/Z/P flags. The address adder forms
//   base (PC or SR1) plus a sign-extended IR offset, optionally doubled.
//   Its result is exported combinationally on ADDR and is one of the PC
//   load sources.
//
//   Optional feature: define BRANCH_STATS_EN to build saturating 16-bit
//   branch statistics counters. When it is undefined, br_count and
//   taken_count read as zero and stat_clr is ignored.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   IR                 instruction register (nzp in [11:9], offsets below)
//   N, Z, P            registered condition codes
//   LD_BEN, LD_PC      load strobes for BEN and PC
//   PCMUX              00 PC+2, 01 BUS, 10 ADDR, 11 hold
//   ADDR1MUX           adder base: 0 PC, 1 SR1
//   ADDR2MUX           adder offset: 00 zero, 01 IR[5:0], 10 IR[8:0], 11 IR[10:0]
//   LSHF1              double the offset before the add
//   SR1, BUS           base register value, system bus
//   PC, BEN            registered outputs
//   ADDR               combinational adder result
//   stat_clr           clear statistics counters
//   br_count           number of BEN evaluations
//   taken_count        number of evaluations that produced BEN=1
module branch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        LD_BEN,
  input  logic        LD_PC,
  input  logic [1:0]  PCMUX,
  input  logic        ADDR1MUX,
  input  logic [1:0]  ADDR2MUX,
  input  logic        LSHF1,
  input  logic [15:0] SR1,
  input  logic [15:0] BUS,
  output logic [15:0] PC,
  output logic        BEN,
  output logic [15:0] ADDR,
  input  logic        stat_clr,
  output logic [15:0] br_count,
  output logic [15:0] taken_count
);

  logic [15:0] pc_q, pc_d;
  logic        ben_q, ben_d;
  logic        ben_new;
  logic [15:0] base;
  logic [15:0] op2;
  logic [15:0] op2_sh;

  // IR[15:12] is the opcode field; the sequencer decodes it elsewhere.
  logic [3:0] unused_ir;
  assign unused_ir = IR[15:12];

  always_comb begin
    base = ADDR1MUX ? SR1 : pc_q;
    op2  = 16'h0000;
    case (ADDR2MUX)
      2'b00: op2 = 16'h0000;
      2'b01: op2 = {{10{IR[5]}}, IR[5:0]};
      2'b10: op2 = {{7{IR[8]}}, IR[8:0]};
      2'b11: op2 = {{5{IR[10]}}, IR[10:0]};
      default: op2 = 16'h0000;
    endcase
    // The shift drops op2[15]; the add drops its carry (mod 2^16).
    op2_sh = LSHF1 ? {op2[14:0], 1'b0} : op2;
    ADDR   = base + op2_sh;
  end

  always_comb begin
    ben_new = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
    ben_d   = LD_BEN ? ben_new : ben_q;

    pc_d = pc_q;
    if (LD_PC) begin
      case (PCMUX)
        2'b00:   pc_d = pc_q + 16'd2;
        2'b01:   pc_d = BUS;
        2'b10:   pc_d = ADDR;
        default: pc_d = pc_q;
      endcase
      // Word alignment: bit 0 of every loaded PC is cleared.
      pc_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= {RESET_PC[15:1], 1'b0};
      ben_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ben_q <= ben_d;
    end
  end

  assign PC  = pc_q;
  assign BEN = ben_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] br_count_q, br_count_d;
  logic [15:0] taken_count_q, taken_count_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (stat_clr) begin
      br_count_d    = 16'h0000;
      taken_count_d = 16'h0000;
    end else if (LD_BEN) begin
      br_count_d = sat_inc(br_count_q);
      if (ben_new) taken_count_d = sat_inc(taken_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q    <= 16'h0000;
      taken_count_q <= 16'h0000;
    end else begin
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign br_count        = 16'h0000;
  assign taken_count     = 16'h0000;
`endif

endmodule
